// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake,
// holds the instruction until release, then selects sequential/branch/jump.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        PCSrc,
    input  logic        j,
    input  logic [31:0] branch_offset,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [31:0] pc_plus4,
    output logic        instr_valid
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    state_t      state;
    logic [31:0] pc;
    logic [31:0] next_pc;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign opcode    = instr[31:26];
    assign funct     = instr[5:0];

    // Jump beats branch when both are asserted.
    always_comb begin
        next_pc = pc_plus4;
        if (j)
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        else if (PCSrc)
            next_pc = pc_plus4 + (branch_offset << 2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= PC_INIT;
            instr       <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        state       <= HOLD;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pc          <= next_pc;
                        state       <= FETCH;
                        imem_req    <= 1'b1;
                        instr_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed table-driven bench for instr_fetch_unit; four instances with
// different reset PCs share the same stimulus and run in lockstep.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        PCSrc = 1'b0;
    logic        j = 1'b0;
    logic [31:0] branch_offset = '0;

    logic        req   [4];
    logic [31:0] addr  [4];
    logic [31:0] ins   [4];
    logic [5:0]  opc   [4];
    logic [5:0]  fun   [4];
    logic [31:0] plus4 [4];
    logic        valid [4];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) u0 (
        .clk(clk), .rst_n(rst_n), .imem_req(req[0]), .imem_addr(addr[0]),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .PCSrc(PCSrc), .j(j), .branch_offset(branch_offset), .instr(ins[0]),
        .opcode(opc[0]), .funct(fun[0]), .pc_plus4(plus4[0]), .instr_valid(valid[0]));

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u1 (
        .clk(clk), .rst_n(rst_n), .imem_req(req[1]), .imem_addr(addr[1]),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .PCSrc(PCSrc), .j(j), .branch_offset(branch_offset), .instr(ins[1]),
        .opcode(opc[1]), .funct(fun[1]), .pc_plus4(plus4[1]), .instr_valid(valid[1]));

    instr_fetch_unit #(.RESET_PC(32'h0000_0003)) u2 (
        .clk(clk), .rst_n(rst_n), .imem_req(req[2]), .imem_addr(addr[2]),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .PCSrc(PCSrc), .j(j), .branch_offset(branch_offset), .instr(ins[2]),
        .opcode(opc[2]), .funct(fun[2]), .pc_plus4(plus4[2]), .instr_valid(valid[2]));

    instr_fetch_unit #(.RESET_PC(32'h4000_0010)) u3 (
        .clk(clk), .rst_n(rst_n), .imem_req(req[3]), .imem_addr(addr[3]),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .PCSrc(PCSrc), .j(j), .branch_offset(branch_offset), .instr(ins[3]),
        .opcode(opc[3]), .funct(fun[3]), .pc_plus4(plus4[3]), .instr_valid(valid[3]));

    typedef struct {
        logic        rst_n, ack, stall, pcsrc, jmp;
        logic [31:0] off, rdata;
        logic        req, valid;
        logic [31:0] instr, a0, a1, a3;
    } vec_t;

    vec_t tv[$];

    localparam logic [31:0] R1 = 32'hFFFF_FFFC;
    localparam logic [31:0] R3 = 32'h4000_0010;

    task automatic add(input logic r, input logic ack, input logic st, input logic pcs,
                       input logic jj, input logic [31:0] off, input logic [31:0] rd,
                       input logic rq, input logic v, input logic [31:0] ei,
                       input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a3);
        vec_t t;
        t.rst_n = r; t.ack = ack; t.stall = st; t.pcsrc = pcs; t.jmp = jj;
        t.off = off; t.rdata = rd; t.req = rq; t.valid = v; t.instr = ei;
        t.a0 = a0; t.a1 = a1; t.a3 = a3;
        tv.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    int n;

    initial begin
        // Sequential fetch, zero-wait memory
        add(0,0,0,0,0,0,0,                 0,0,0,            0,     R1,    R3);
        add(1,0,0,0,0,0,0,                 0,0,0,            0,     R1,    R3);
        add(1,1,0,0,0,0,32'h0000_0020,     1,0,0,            0,     R1,    R3);
        add(1,0,0,0,0,0,0,                 0,1,32'h0000_0020,0,     R1,    R3);
        add(1,1,0,0,0,0,32'h8C01_0004,     1,0,32'h0000_0020,4,     0,     R3+4);
        add(1,0,0,0,0,0,0,                 0,1,32'h8C01_0004,4,     0,     R3+4);
        add(1,1,0,0,0,0,32'h0022_1820,     1,0,32'h8C01_0004,8,     4,     R3+8);
        add(1,0,0,0,0,0,0,                 0,1,32'h0022_1820,8,     4,     R3+8);
        add(1,0,0,0,0,0,0,                 1,0,32'h0022_1820,12,    8,     R3+12);
        // Async reset mid-FETCH with ack pending; ack in IDLE ignored
        add(0,1,0,0,0,0,32'hDEAD_BEEF,     0,0,0,            0,     R1,    R3);
        add(1,1,0,0,0,0,32'hDEAD_BEEF,     0,0,0,            0,     R1,    R3);
        // Wait states then stall (controls ignored while stalled)
        add(1,0,0,0,0,0,0,                 1,0,0,            0,     R1,    R3);
        add(1,0,0,0,0,0,0,                 1,0,0,            0,     R1,    R3);
        add(1,0,0,0,0,0,0,                 1,0,0,            0,     R1,    R3);
        add(1,1,0,0,0,0,32'h0800_0040,     1,0,0,            0,     R1,    R3);
        add(1,0,1,1,1,8,0,                 0,1,32'h0800_0040,0,     R1,    R3);
        add(1,0,1,1,1,8,0,                 0,1,32'h0800_0040,0,     R1,    R3);
        add(1,0,0,0,0,0,0,                 0,1,32'h0800_0040,0,     R1,    R3);
        add(1,0,0,0,0,0,0,                 1,0,32'h0800_0040,4,     0,     R3+4);
        // Jump priority, then branches backward and forward
        add(0,0,0,0,0,0,0,                 0,0,0,            0,     R1,    R3);
        add(1,0,0,0,0,0,0,                 0,0,0,            0,     R1,    R3);
        add(1,1,0,0,0,0,32'h0800_0040,     1,0,0,            0,     R1,    R3);
        add(1,0,0,1,1,8,0,                 0,1,32'h0800_0040,0,     R1,    R3);
        add(1,1,0,0,0,0,32'h1000_FFFE,     1,0,32'h0800_0040,32'h100,32'h100,32'h4000_0100);
        add(1,0,0,1,0,32'hFFFF_FFFE,0,     0,1,32'h1000_FFFE,32'h100,32'h100,32'h4000_0100);
        add(1,1,0,0,0,0,0,                 1,0,32'h1000_FFFE,32'hFC, 32'hFC, 32'h4000_00FC);
        add(1,0,0,0,0,0,0,                 0,1,0,            32'hFC, 32'hFC, 32'h4000_00FC);
        add(1,1,0,0,0,0,32'h1000_0003,     1,0,0,            32'h100,32'h100,32'h4000_0100);
        add(1,0,0,1,0,3,0,                 0,1,32'h1000_0003,32'h100,32'h100,32'h4000_0100);
        add(1,0,0,0,0,0,0,                 1,0,32'h1000_0003,32'h110,32'h110,32'h4000_0110);

        for (int i = 0; i < tv.size(); i++) begin
            @(posedge clk); #1;
            rst_n = tv[i].rst_n; imem_ack = tv[i].ack; stall = tv[i].stall;
            PCSrc = tv[i].pcsrc; j = tv[i].jmp; branch_offset = tv[i].off;
            imem_rdata = tv[i].rdata;
            #1;
            chk($sformatf("row%0d req", i),    {31'b0, req[0]},   {31'b0, tv[i].req});
            chk($sformatf("row%0d valid", i),  {31'b0, valid[0]}, {31'b0, tv[i].valid});
            chk($sformatf("row%0d instr", i),  ins[0],            tv[i].instr);
            chk($sformatf("row%0d opcode", i), {26'b0, opc[0]},   {26'b0, tv[i].instr[31:26]});
            chk($sformatf("row%0d funct", i),  {26'b0, fun[0]},   {26'b0, tv[i].instr[5:0]});
            chk($sformatf("row%0d addr0", i),  addr[0],           tv[i].a0);
            chk($sformatf("row%0d plus4_0", i),plus4[0],          tv[i].a0 + 32'd4);
            chk($sformatf("row%0d addr1", i),  addr[1],           tv[i].a1);
            chk($sformatf("row%0d plus4_1", i),plus4[1],          tv[i].a1 + 32'd4);
            chk($sformatf("row%0d addr2", i),  addr[2],           tv[i].a0);
            chk($sformatf("row%0d addr3", i),  addr[3],           tv[i].a3);
        end

        // Reset mid-HOLD: held instruction lost immediately
        @(posedge clk); #1;
        imem_ack = 1'b1; imem_rdata = 32'hAAAA_5555;
        @(posedge clk); #1;
        imem_ack = 1'b0; stall = 1'b1;
        #1;
        chk("hold valid", {31'b0, valid[0]}, 32'd1);
        chk("hold instr", ins[0], 32'hAAAA_5555);
        rst_n = 1'b0;
        #1;
        chk("rst hold valid", {31'b0, valid[0]}, 32'd0);
        chk("rst hold req",   {31'b0, req[0]},   32'd0);
        chk("rst hold instr", ins[0], 32'd0);
        chk("rst hold opcode", {26'b0, opc[0]}, 32'd0);
        chk("rst hold funct",  {26'b0, fun[0]}, 32'd0);
        chk("rst hold addr3", addr[3], R3);

        // Restart: first request in the second cycle, at the reset PC
        @(posedge clk); #1;
        rst_n = 1'b1; stall = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        n = 1;
        while (!req[0] && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("restart req cycle", n, 32'd2);
        chk("restart addr0", addr[0], 32'd0);
        chk("restart addr3", addr[3], R3);
        @(posedge clk); #1;
        chk("restart instr", ins[0], 32'h1234_5678);
        chk("restart valid", {31'b0, valid[0]}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
